// File: rtl/bus_terminal_fifo.sv
// Per-terminal bus endpoint: a TX FIFO loaded by the host and drained by the bus
// through pndng/pop/D_pop, plus an address-filtered RX FIFO that captures bus
// push traffic for this terminal (or broadcast) and presents it to the host.
module bus_terminal_fifo #(
  parameter int unsigned pckg_sz   = 16,
  parameter int unsigned depth     = 8,
  parameter logic [7:0]  id        = 8'h00,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tx_wr,
  input  logic [pckg_sz-1:0]        tx_data,
  output logic                      tx_full,
  output logic [$clog2(depth):0]    tx_count,
  output logic [7:0]                tx_drop,
  output logic                      pndng,
  output logic [pckg_sz-1:0]        D_pop,
  input  logic                      pop,
  input  logic                      push,
  input  logic [pckg_sz-1:0]        D_push,
  output logic                      rx_valid,
  output logic [pckg_sz-1:0]        rx_data,
  input  logic                      rx_rd,
  output logic [$clog2(depth):0]    rx_count,
  output logic [7:0]                rx_ovf,
  output logic [7:0]                rx_miss,
  output logic                      pop_err
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  logic [pckg_sz-1:0] tx_mem [depth];
  logic [pckg_sz-1:0] rx_mem [depth];
  logic [AW-1:0]      tx_rp, tx_wp, rx_rp, rx_wp;
  logic [CW-1:0]      tx_cnt_nxt, rx_cnt_nxt;

  logic tx_pop_ok, tx_wr_ok, tx_wr_drop, pop_bad;
  logic rx_hit, rx_rd_ok, rx_wr_ok, rx_lost, rx_filtered;

  // TX handshake decode; a full FIFO still takes a write when the bus pops the same cycle
  always_comb begin
    tx_pop_ok  = pop && pndng;
    pop_bad    = pop && !pndng;
    tx_wr_ok   = tx_wr && (!tx_full || tx_pop_ok);
    tx_wr_drop = tx_wr && !tx_wr_ok;
  end

  // RX address filter and handshake decode
  always_comb begin
    rx_hit      = push && ((D_push[pckg_sz-1 -: 8] == id) ||
                           (D_push[pckg_sz-1 -: 8] == broadcast));
    rx_filtered = push && !rx_hit;
    rx_rd_ok    = rx_rd && rx_valid;
    rx_wr_ok    = rx_hit && (!rx_full_q() || rx_rd_ok);
    rx_lost     = rx_hit && !rx_wr_ok;
  end

  function automatic logic rx_full_q();
    return rx_count == FULL_CNT;
  endfunction

  // Next occupancy values, shared by the count registers and the registered flags
  always_comb begin
    tx_cnt_nxt = tx_count;
    case ({tx_wr_ok, tx_pop_ok})
      2'b10:   tx_cnt_nxt = tx_count + 1'b1;
      2'b01:   tx_cnt_nxt = tx_count - 1'b1;
      default: tx_cnt_nxt = tx_count;
    endcase
    rx_cnt_nxt = rx_count;
    case ({rx_wr_ok, rx_rd_ok})
      2'b10:   rx_cnt_nxt = rx_count + 1'b1;
      2'b01:   rx_cnt_nxt = rx_count - 1'b1;
      default: rx_cnt_nxt = rx_count;
    endcase
  end

  // FIFO storage; contents are deliberately left untouched by reset
  always_ff @(posedge clk) begin
    if (tx_wr_ok) tx_mem[tx_wp] <= tx_data;
    if (rx_wr_ok) rx_mem[rx_wp] <= D_push;
  end

  // Pointers, occupancy and registered status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_rp    <= '0;
      tx_wp    <= '0;
      rx_rp    <= '0;
      rx_wp    <= '0;
      tx_count <= '0;
      rx_count <= '0;
      pndng    <= 1'b0;
      tx_full  <= 1'b0;
      rx_valid <= 1'b0;
    end else begin
      if (tx_wr_ok)  tx_wp <= tx_wp + 1'b1;
      if (tx_pop_ok) tx_rp <= tx_rp + 1'b1;
      if (rx_wr_ok)  rx_wp <= rx_wp + 1'b1;
      if (rx_rd_ok)  rx_rp <= rx_rp + 1'b1;
      tx_count <= tx_cnt_nxt;
      rx_count <= rx_cnt_nxt;
      pndng    <= (tx_cnt_nxt != '0);
      tx_full  <= (tx_cnt_nxt == FULL_CNT);
      rx_valid <= (rx_cnt_nxt != '0);
    end
  end

  // Saturating event counters and the sticky pop error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_drop <= '0;
      rx_ovf  <= '0;
      rx_miss <= '0;
      pop_err <= 1'b0;
    end else begin
      if (tx_wr_drop  && tx_drop != '1) tx_drop <= tx_drop + 8'd1;
      if (rx_lost     && rx_ovf  != '1) rx_ovf  <= rx_ovf  + 8'd1;
      if (rx_filtered && rx_miss != '1) rx_miss <= rx_miss + 8'd1;
      if (pop_bad) pop_err <= 1'b1;
    end
  end

  // First-word fall-through heads, forced to zero while the FIFO is empty
  always_comb begin
    D_pop   = pndng    ? tx_mem[tx_rp] : '0;
    rx_data = rx_valid ? rx_mem[rx_rp] : '0;
  end

endmodule

// File: tb/tb_bus_terminal_fifo.sv
// Directed bench for bus_terminal_fifo (id=3, depth=8, 16-bit packets).
module tb_bus_terminal_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_wr, pop, push, rx_rd;
  logic [15:0] tx_data, D_push;
  logic        tx_full, pndng, rx_valid, pop_err;
  logic [3:0]  tx_count, rx_count;
  logic [7:0]  tx_drop, rx_ovf, rx_miss;
  logic [15:0] D_pop, rx_data;

  int errors = 0;
  int checks = 0;

  bus_terminal_fifo #(.pckg_sz(16), .depth(8), .id(8'h03), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .tx_count(tx_count),
    .tx_drop(tx_drop), .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_rd(rx_rd), .rx_count(rx_count), .rx_ovf(rx_ovf), .rx_miss(rx_miss),
    .pop_err(pop_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;   logic [15:0] txd; logic pop;
    logic        push; logic [15:0] dp;  logic rd;
    logic        e_pndng; logic [15:0] e_dpop; logic [3:0] e_txc;
    logic        e_rxv;   logic [15:0] e_rxd;  logic [3:0] e_rxc;
    logic        e_perr;  logic [7:0]  e_miss;
  } vec_t;

  function automatic vec_t mk(logic wr, logic [15:0] txd, logic p, logic ps,
                              logic [15:0] dp, logic rd, logic e_pn, logic [15:0] e_dpop,
                              logic [3:0] e_txc, logic e_rxv, logic [15:0] e_rxd,
                              logic [3:0] e_rxc, logic e_perr, logic [7:0] e_miss);
    vec_t v;
    v.wr = wr; v.txd = txd; v.pop = p; v.push = ps; v.dp = dp; v.rd = rd;
    v.e_pndng = e_pn; v.e_dpop = e_dpop; v.e_txc = e_txc;
    v.e_rxv = e_rxv; v.e_rxd = e_rxd; v.e_rxc = e_rxc;
    v.e_perr = e_perr; v.e_miss = e_miss;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tx_wr = 0; tx_data = '0; pop = 0; push = 0; D_push = '0; rx_rd = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " pndng"}, pndng, 0);       chk({tag, " tx_full"}, tx_full, 0);
    chk({tag, " tx_count"}, tx_count, 0); chk({tag, " tx_drop"}, tx_drop, 0);
    chk({tag, " D_pop"}, D_pop, 0);       chk({tag, " rx_valid"}, rx_valid, 0);
    chk({tag, " rx_data"}, rx_data, 0);   chk({tag, " rx_count"}, rx_count, 0);
    chk({tag, " rx_ovf"}, rx_ovf, 0);     chk({tag, " rx_miss"}, rx_miss, 0);
    chk({tag, " pop_err"}, pop_err, 0);
  endtask

  vec_t vt [18];

  initial begin
    // {inputs} -> state visible just after the sampling edge
    vt[0]  = mk(1,16'h0011,0, 0,16'h0000,0, 1,16'h0011,1, 0,16'h0000,0, 0,0);
    vt[1]  = mk(1,16'h0122,0, 0,16'h0000,0, 1,16'h0011,2, 0,16'h0000,0, 0,0);
    vt[2]  = mk(1,16'h0233,0, 0,16'h0000,0, 1,16'h0011,3, 0,16'h0000,0, 0,0);
    vt[3]  = mk(0,16'h0000,1, 0,16'h0000,0, 1,16'h0122,2, 0,16'h0000,0, 0,0);
    vt[4]  = mk(0,16'h0000,1, 0,16'h0000,0, 1,16'h0233,1, 0,16'h0000,0, 0,0);
    vt[5]  = mk(0,16'h0000,1, 0,16'h0000,0, 0,16'h0000,0, 0,16'h0000,0, 0,0);
    vt[6]  = mk(0,16'h0000,1, 0,16'h0000,0, 0,16'h0000,0, 0,16'h0000,0, 1,0);
    vt[7]  = mk(1,16'h0044,1, 0,16'h0000,0, 1,16'h0044,1, 0,16'h0000,0, 1,0);
    vt[8]  = mk(0,16'h0000,1, 0,16'h0000,0, 0,16'h0000,0, 0,16'h0000,0, 1,0);
    vt[9]  = mk(0,16'h0000,0, 1,16'h03AA,0, 0,16'h0000,0, 1,16'h03AA,1, 1,0);
    vt[10] = mk(0,16'h0000,0, 1,16'hFF55,0, 0,16'h0000,0, 1,16'h03AA,2, 1,0);
    vt[11] = mk(0,16'h0000,0, 1,16'h07BB,0, 0,16'h0000,0, 1,16'h03AA,2, 1,1);
    vt[12] = mk(0,16'h0000,0, 0,16'h0000,1, 0,16'h0000,0, 1,16'hFF55,1, 1,1);
    vt[13] = mk(0,16'h0000,0, 0,16'h0000,1, 0,16'h0000,0, 0,16'h0000,0, 1,1);
    vt[14] = mk(0,16'h0000,0, 0,16'h0000,1, 0,16'h0000,0, 0,16'h0000,0, 1,1);
    vt[15] = mk(1,16'h0055,0, 1,16'h03CC,0, 1,16'h0055,1, 1,16'h03CC,1, 1,1);
    vt[16] = mk(0,16'h0000,1, 1,16'h0311,1, 0,16'h0000,0, 1,16'h0311,1, 1,1);
    vt[17] = mk(0,16'h0000,0, 0,16'h0000,1, 0,16'h0000,0, 0,16'h0000,0, 1,1);

    idle();
    reset = 1;
    step();
    step();
    chk_all_zero("reset");
    reset = 0;
    step();
    chk_all_zero("post_reset");

    for (int i = 0; i < 18; i++) begin
      tx_wr = vt[i].wr; tx_data = vt[i].txd; pop = vt[i].pop;
      push = vt[i].push; D_push = vt[i].dp; rx_rd = vt[i].rd;
      step();
      chk($sformatf("v%0d pndng", i),    pndng,    vt[i].e_pndng);
      chk($sformatf("v%0d D_pop", i),    D_pop,    vt[i].e_dpop);
      chk($sformatf("v%0d tx_count", i), tx_count, vt[i].e_txc);
      chk($sformatf("v%0d tx_full", i),  tx_full,  0);
      chk($sformatf("v%0d tx_drop", i),  tx_drop,  0);
      chk($sformatf("v%0d rx_valid", i), rx_valid, vt[i].e_rxv);
      chk($sformatf("v%0d rx_data", i),  rx_data,  vt[i].e_rxd);
      chk($sformatf("v%0d rx_count", i), rx_count, vt[i].e_rxc);
      chk($sformatf("v%0d pop_err", i),  pop_err,  vt[i].e_perr);
      chk($sformatf("v%0d rx_miss", i),  rx_miss,  vt[i].e_miss);
      chk($sformatf("v%0d rx_ovf", i),   rx_ovf,   0);
    end
    idle();

    // TX overflow, write-with-pop at full, drain across pointer wrap
    for (int i = 0; i < 9; i++) begin
      tx_wr = 1; tx_data = 16'h0100 + 16'(i);
      step();
    end
    idle();
    chk("txfull full", tx_full, 1);
    chk("txfull count", tx_count, 8);
    chk("txfull drop", tx_drop, 1);
    chk("txfull head", D_pop, 16'h0100);
    tx_wr = 1; tx_data = 16'h0200; pop = 1;
    step();
    idle();
    chk("txwp count", tx_count, 8);
    chk("txwp full", tx_full, 1);
    chk("txwp drop", tx_drop, 1);
    chk("txwp head", D_pop, 16'h0101);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("txdrain%0d", i), D_pop, (i == 7) ? 16'h0200 : 16'h0101 + 16'(i));
      pop = 1;
      step();
    end
    idle();
    chk("txdrain pndng", pndng, 0);
    chk("txdrain count", tx_count, 0);

    // RX overflow and read-with-push at full
    for (int i = 0; i < 8; i++) begin
      push = 1; D_push = 16'h0300 + 16'(i);
      step();
    end
    chk("rxfill count", rx_count, 8);
    chk("rxfill ovf", rx_ovf, 0);
    push = 1; D_push = 16'h03F0;
    step();
    chk("rxovf ovf", rx_ovf, 1);
    chk("rxovf count", rx_count, 8);
    push = 1; D_push = 16'h03F1; rx_rd = 1;
    step();
    idle();
    chk("rxwr count", rx_count, 8);
    chk("rxwr ovf", rx_ovf, 1);
    chk("rxwr head", rx_data, 16'h0301);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rxdrain%0d", i), rx_data, (i == 7) ? 16'h03F1 : 16'h0301 + 16'(i));
      rx_rd = 1;
      step();
    end
    idle();
    chk("rxdrain valid", rx_valid, 0);

    // Asynchronous reset in the middle of a drain
    for (int i = 0; i < 5; i++) begin
      tx_wr = 1; tx_data = 16'h0500 + 16'(i);
      push = (i < 3); D_push = 16'hFF00 + 16'(i);
      step();
    end
    idle();
    chk("pre_rst tx_count", tx_count, 5);
    chk("pre_rst rx_count", rx_count, 3);
    pop = 1;
    step();
    chk("pre_rst pop", D_pop, 16'h0501);
    #3;
    reset = 1;
    #1;
    chk_all_zero("async_rst");
    idle();
    step();
    reset = 0;
    #1;
    chk("rel pndng", pndng, 0);
    tx_wr = 1; tx_data = 16'h0ABC;
    step();
    idle();
    chk("rel_wr pndng", pndng, 1);
    chk("rel_wr D_pop", D_pop, 16'h0ABC);
    chk("rel_wr count", tx_count, 1);

    // Saturation of the miss counter
    for (int i = 0; i < 260; i++) begin
      push = 1; D_push = 16'h0700;
      step();
    end
    idle();
    chk("miss_sat", rx_miss, 255);
    chk("miss_sat rx_count", rx_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_terminal_fifo.md
# bus_terminal_fifo

Per-terminal endpoint for the `bs_gnrtr_n_rbtr` bus: the device-side counterpart of the bus's `pndng`/`pop`/`D_pop` and `push`/`D_push` handshakes. One instance sits on each of the `drvrs` bus ports.
- A transmit FIFO is loaded by a local host and drained by the bus through `pndng`/`pop`/`D_pop`.
- A receive FIFO captures bus `push` traffic addressed to this terminal's ID or to the broadcast ID, and presents it to the host.

## Interface
Parameters:
- `pckg_sz`, 16: packet width in bits; bits `[pckg_sz-1 -: 8]` hold the destination ID, the remainder is payload; minimum 9.
- `depth`, 8: entries per FIFO; power of two, at least 2.
- `id`, 0: this terminal's 8-bit ID; must not equal `broadcast`.
- `broadcast`, 8'hFF: broadcast destination ID.

Ports (`CW` = $clog2(depth)+1):
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `tx_wr`  in  1  host write strobe into the TX FIFO.
- `tx_data`  in  pckg_sz  host packet to transmit.
- `tx_full`  out  1  TX FIFO holds `depth` entries.
- `tx_count`  out  CW  TX FIFO occupancy.
- `tx_drop`  out  8  saturating count of writes refused because the TX FIFO was full.
- `pndng`  out  1  TX FIFO non-empty; requests service from the bus.
- `D_pop`  out  pckg_sz  TX FIFO head (first-word fall-through).
- `pop`  in  1  bus consumes `D_pop` this cycle.
- `push`  in  1  bus delivers `D_push` this cycle.
- `D_push`  in  pckg_sz  packet from the bus.
- `rx_valid`  out  1  RX FIFO non-empty.
- `rx_data`  out  pckg_sz  RX FIFO head (first-word fall-through).
- `rx_rd`  in  1  host consumes `rx_data`.
- `rx_count`  out  CW  RX FIFO occupancy.
- `rx_ovf`  out  8  saturating count of accepted-address pushes lost because the RX FIFO was full.
- `rx_miss`  out  8  saturating count of pushes filtered out by address.
- `pop_err`  out  1  sticky flag: `pop` was seen while `pndng` was low.

## Operation
- Each FIFO is a circular buffer with read/write pointers of $clog2(depth) bits that wrap modulo `depth`, plus an occupancy counter of `CW` bits.
- TX write: `tx_wr` is accepted when not full, or when full and `pop` is asserted in the same cycle (the pop frees a slot, occupancy unchanged). Otherwise the write is dropped and `tx_drop` increments.
- TX read: `pop` with `pndng` high advances the read pointer. `pop` with `pndng` low is ignored and sets `pop_err`.
- When the TX FIFO is empty and `tx_wr` and `pop` arrive together, the write is accepted, the pop is ignored and `pop_err` is set.
- RX filter: a `push` is a hit when `D_push[pckg_sz-1 -: 8]` equals `id` or `broadcast`.
  - A miss increments `rx_miss` and is discarded.
  - A hit is enqueued if not full, or if full and `rx_rd` is asserted in the same cycle; otherwise `rx_ovf` increments.
- RX read: `rx_rd` with `rx_valid` high advances the read pointer; `rx_rd` on empty is ignored and sets no flag.
- All 8-bit counters saturate at 255. Only reset clears `pop_err` and the counters.
- Reset (asynchronous, any time, including mid-transfer) empties both FIFOs. All outputs go to 0: `pndng`, `tx_full`, `rx_valid`, counts, counters and `pop_err`. `D_pop` and `rx_data` read 0 while their FIFO is empty. Storage contents are not cleared.

## Timing
- `pndng`, `tx_full`, `tx_count`, `rx_valid` and `rx_count` are registered. Each reflects an accepted write or read from the rising edge that samples it.
- Write-to-`pndng` latency: 1 cycle. `push`-to-`rx_valid` latency: 1 cycle.
- `D_pop` and `rx_data` are combinational reads of the head entry. They are stable for the whole cycle in which `pop`/`rx_rd` is sampled, and show the next entry in the following cycle.
- Back-to-back `pop` every cycle drains one entry per cycle. `pndng` falls in the cycle after the last entry is popped.
- Sustained simultaneous write and pop keeps occupancy constant at any fill level ≥1.

## Test plan
- Reset, write 3 packets 16'h0011/16'h0122/16'h0233 on consecutive cycles, then hold `pop` high → `pndng` rises 1 cycle after the first write; `D_pop` shows 0011, 0122, 0233 on successive pops; `pndng` falls after the third pop; `tx_count` ends at 0.
- Write 9 packets with `depth`=8 and no pops → `tx_full`=1, `tx_count`=8, `tx_drop`=1. Then write and pop in the same cycle → accepted, `tx_count` stays 8.
- `id`=3: push 16'h03AA, 16'hFF55 and 16'h07BB → `rx_count`=2, `rx_miss`=1, and reads return 03AA then FF55.
- Fill the RX FIFO with 8 hits, then push a 9th hit without `rx_rd` → `rx_ovf`=1. Push a 10th hit with `rx_rd` in the same cycle → accepted, `rx_count` stays 8.
- `pop` asserted while empty → `pop_err`=1 and stays set after later valid traffic; `tx_count` unchanged.
- Assert `reset` mid-drain with 5 TX and 3 RX entries → all outputs are 0 immediately (asynchronously). After release, a single write raises `pndng` 1 cycle later with the new data on `D_pop`.
